// File: rtl/fifo_wr_arbiter_ctrl_if.sv
// rtl/fifo_wr_arbiter_ctrl_if.sv - requester, consumer and memory-control signals of the FIFO write arbiter
interface fifo_wr_arbiter_ctrl_if #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ    = 4
);
  localparam int AW = $clog2(DEPTH);

  logic [NUM_REQ-1:0]            i_req;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            o_grant;
  logic                          i_rd_en;
  logic                          o_wr_en;
  logic [DATA_WIDTH-1:0]         o_wr_data;
  logic [AW:0]                   o_b_wr_ptr;
  logic                          o_rd_en;
  logic [AW:0]                   o_b_rd_ptr;
  logic                          o_full;
  logic                          o_empty;
  logic [AW:0]                   o_count;
  logic                          o_rd_valid;

  modport slave (
    input  i_req, i_req_data, i_rd_en,
    output o_grant, o_wr_en, o_wr_data, o_b_wr_ptr, o_rd_en, o_b_rd_ptr,
           o_full, o_empty, o_count, o_rd_valid
  );

  modport master (
    output i_req, i_req_data, i_rd_en,
    input  o_grant, o_wr_en, o_wr_data, o_b_wr_ptr, o_rd_en, o_b_rd_ptr,
           o_full, o_empty, o_count, o_rd_valid
  );
endinterface

// File: rtl/fifo_wr_arbiter_ctrl.sv
// rtl/fifo_wr_arbiter_ctrl.sv - round-robin write arbiter and pointer/status owner for a dual-port FIFO memory
module fifo_wr_arbiter_ctrl #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 4,
  parameter int NUM_REQ    = 4
) (
  input logic                   i_clk,
  input logic                   i_rst,
  fifo_wr_arbiter_ctrl_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(NUM_REQ);

  logic [AW:0]           wr_ptr;
  logic [AW:0]           rd_ptr;
  logic [IW-1:0]         last_grant;
  logic                  rd_valid;
  logic                  full;
  logic                  empty;
  logic                  rd_en;
  logic                  wr_en;
  logic                  found;
  logic [NUM_REQ-1:0]    grant;
  logic [IW-1:0]         grant_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  int                    cand;

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_en = bus.i_rd_en & ~empty;
  assign wr_en = |grant;

  // Search starts one past the last winner; reset is gated in so nothing is granted while held.
  always_comb begin
    grant     = '0;
    grant_idx = last_grant;
    found     = 1'b0;
    cand      = 0;
    if (!full && !i_rst) begin
      for (int i = 1; i <= NUM_REQ; i++) begin
        cand = (int'(last_grant) + i) % NUM_REQ;
        for (int k = 0; k < NUM_REQ; k++) begin
          if (!found && (k == cand) && bus.i_req[k]) begin
            found     = 1'b1;
            grant[k]  = 1'b1;
            grant_idx = IW'(k);
          end
        end
      end
    end
  end

  always_comb begin
    wr_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (grant[k]) wr_data = bus.i_req_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      last_grant <= IW'(NUM_REQ - 1);
      rd_valid   <= 1'b0;
    end else begin
      if (wr_en) begin
        wr_ptr     <= wr_ptr + 1'b1;
        last_grant <= grant_idx;
      end
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      rd_valid <= rd_en;
    end
  end

  assign bus.o_grant    = grant;
  assign bus.o_wr_en    = wr_en;
  assign bus.o_wr_data  = wr_data;
  assign bus.o_b_wr_ptr = wr_ptr;
  assign bus.o_rd_en    = rd_en;
  assign bus.o_b_rd_ptr = rd_ptr;
  assign bus.o_full     = full;
  assign bus.o_empty    = empty;
  assign bus.o_count    = wr_ptr - rd_ptr;
  assign bus.o_rd_valid = rd_valid;
endmodule

// File: tb/tb_fifo_wr_arbiter_ctrl.sv
// tb/tb_fifo_wr_arbiter_ctrl.sv - random and directed bench for fifo_wr_arbiter_ctrl against an occupancy-counting model
module tb_fifo_wr_arbiter_ctrl;
  localparam int DEPTH = 8;
  localparam int DW    = 4;
  localparam int NR    = 4;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NR-1:0]    req      = '0;
  logic [NR*DW-1:0] req_data = '0;
  logic             rd       = 1'b0;

  fifo_wr_arbiter_ctrl_if #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .NUM_REQ(NR)) bus ();
  assign bus.i_req      = req;
  assign bus.i_req_data = req_data;
  assign bus.i_rd_en    = rd;

  fifo_wr_arbiter_ctrl #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: total words written/read since reset, last winner, and a queue of stored words.
  int            wr_total = 0;
  int            rd_total = 0;
  int            last     = NR - 1;
  bit            prev_rd  = 1'b0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_rd   = '0;
  logic [NR-1:0] m_granted = '0;

  logic [DW-1:0] mem[DEPTH];
  logic [DW-1:0] mem_rd = '0;
  logic [DW-1:0] obs_rd_data = '0;

  int            cnt;
  int            g;
  int            k;
  logic [NR-1:0] eg;
  logic [DW-1:0] ed;
  bit            ef;
  bit            ee;
  bit            er;

  always @(negedge clk) begin
    if (rst) begin
      check("rst_grant", 32'(bus.o_grant), 32'd0);
      check("rst_wr_en", 32'(bus.o_wr_en), 32'd0);
      check("rst_rd_en", 32'(bus.o_rd_en), 32'd0);
      check("rst_empty", 32'(bus.o_empty), 32'd1);
      check("rst_full", 32'(bus.o_full), 32'd0);
      check("rst_count", 32'(bus.o_count), 32'd0);
      check("rst_rd_valid", 32'(bus.o_rd_valid), 32'd0);
      wr_total  = 0;
      rd_total  = 0;
      last      = NR - 1;
      prev_rd   = 1'b0;
      m_granted = '0;
      exp_q.delete();
    end else begin
      cnt = wr_total - rd_total;
      ef  = (cnt == DEPTH);
      ee  = (cnt == 0);
      g   = -1;
      if (!ef) begin
        for (int i = 1; i <= NR; i++) begin
          k = (last + i) % NR;
          if (g < 0 && req[k]) g = k;
        end
      end
      eg = '0;
      ed = '0;
      if (g >= 0) begin
        eg[g] = 1'b1;
        ed    = req_data[g*DW +: DW];
      end
      er = rd && !ee;

      check("grant", 32'(bus.o_grant), 32'(eg));
      check("wr_en", 32'(bus.o_wr_en), 32'(g >= 0));
      check("wr_data", 32'(bus.o_wr_data), 32'(ed));
      check("wr_ptr", 32'(bus.o_b_wr_ptr), 32'(wr_total % (2*DEPTH)));
      check("rd_ptr", 32'(bus.o_b_rd_ptr), 32'(rd_total % (2*DEPTH)));
      check("full", 32'(bus.o_full), 32'(ef));
      check("empty", 32'(bus.o_empty), 32'(ee));
      check("count", 32'(bus.o_count), 32'(cnt));
      check("rd_en", 32'(bus.o_rd_en), 32'(er));
      check("rd_valid", 32'(bus.o_rd_valid), 32'(prev_rd));
      if (bus.o_rd_valid) obs_rd_data = mem_rd;
      if (prev_rd) check("rd_data", 32'(mem_rd), 32'(exp_rd));

      // Bench-side memory driven by the DUT's own pointers.
      if (bus.o_wr_en) mem[bus.o_b_wr_ptr[AW-1:0]] = bus.o_wr_data;
      if (bus.o_rd_en) mem_rd = mem[bus.o_b_rd_ptr[AW-1:0]];

      if (g >= 0) begin
        exp_q.push_back(ed);
        wr_total++;
        last = g;
      end
      if (er) begin
        exp_rd = exp_q.pop_front();
        rd_total++;
      end
      prev_rd   = er;
      m_granted = eg;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  int gcnt[NR];
  int rd_bias;

  initial begin
    rst = 1'b1;
    req = 4'b1111;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'(i + 1);
    rd = 1'b0;
    repeat (2) tick();
    mid();
    check("lit_rst_grant", 32'(bus.o_grant), 32'd0);
    check("lit_rst_empty", 32'(bus.o_empty), 32'd1);
    check("lit_rst_count", 32'(bus.o_count), 32'd0);
    tick();
    rst = 1'b0;

    // Rotation until full
    for (int i = 0; i < 8; i++) begin
      mid();
      check("lit_rot_grant", 32'(bus.o_grant), 32'(1 << (i % 4)));
      check("lit_rot_count", 32'(bus.o_count), 32'(i));
      tick();
    end
    mid();
    check("lit_full", 32'(bus.o_full), 32'd1);
    check("lit_full_count", 32'(bus.o_count), 32'd8);
    check("lit_full_grant", 32'(bus.o_grant), 32'd0);

    // Read and request on a full FIFO
    tick();
    req = 4'b0001;
    rd  = 1'b1;
    mid();
    check("lit_fr_grant", 32'(bus.o_grant), 32'd0);
    check("lit_fr_rd_en", 32'(bus.o_rd_en), 32'd1);
    tick();
    mid();
    check("lit_fr_count7", 32'(bus.o_count), 32'd7);
    check("lit_fr_grant1", 32'(bus.o_grant), 32'd1);
    tick();
    mid();
    check("lit_fr_count_hold", 32'(bus.o_count), 32'd7);
    tick();
    req = '0;
    repeat (10) tick();
    mid();
    check("lit_drained", 32'(bus.o_empty), 32'd1);

    // Fresh reset, requester k writes k+1, then four reads
    tick();
    rst = 1'b1;
    rd  = 1'b0;
    tick();
    req = 4'b1111;
    for (int i = 0; i < NR; i++) req_data[i*DW +: DW] = DW'(i + 1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("lit_seq_grant", 32'(bus.o_grant), 32'(1 << i));
      tick();
      req[i] = 1'b0;
    end
    rd = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mid();
      check("lit_seq_rd_en", 32'(bus.o_rd_en), 32'd1);
      if (i > 0) begin
        check("lit_seq_valid", 32'(bus.o_rd_valid), 32'd1);
        check("lit_seq_data", 32'(obs_rd_data), 32'(i));
      end
      tick();
    end
    rd = 1'b0;
    mid();
    check("lit_seq_valid_last", 32'(bus.o_rd_valid), 32'd1);
    check("lit_seq_data_last", 32'(obs_rd_data), 32'd4);
    check("lit_seq_empty", 32'(bus.o_empty), 32'd1);

    // Read on empty with a concurrent write, then paired traffic through pointer wrap
    tick();
    req = 4'b0001;
    req_data[0 +: DW] = 4'd5;
    rd  = 1'b1;
    mid();
    check("lit_emp_rd_en", 32'(bus.o_rd_en), 32'd0);
    check("lit_emp_grant", 32'(bus.o_grant), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      req_data[0 +: DW] = DW'($urandom);
      mid();
      check("lit_pair_count", 32'(bus.o_count), 32'd1);
      check("lit_pair_full", 32'(bus.o_full), 32'd0);
    end

    // Only requesters 0 and 2 active
    tick();
    req = 4'b0101;
    for (int i = 0; i < NR; i++) gcnt[i] = 0;
    for (int i = 0; i < 12; i++) begin
      mid();
      for (int j = 0; j < NR; j++) if (bus.o_grant[j]) gcnt[j]++;
      tick();
    end
    check("lit_alt_g0", 32'(gcnt[0]), 32'd6);
    check("lit_alt_g1", 32'(gcnt[1]), 32'd0);
    check("lit_alt_g2", 32'(gcnt[2]), 32'd6);
    check("lit_alt_g3", 32'(gcnt[3]), 32'd0);
    req = '0;

    // Random traffic, read intensity varied per phase
    rd_bias = 2;
    for (int c = 0; c < 3000; c++) begin
      tick();
      if (c % 250 == 0) rd_bias = int'($urandom_range(0, 4));
      for (int j = 0; j < NR; j++) begin
        if (m_granted[j]) begin
          req[j] = 1'($urandom_range(0, 1));
          req_data[j*DW +: DW] = DW'($urandom);
        end else if (!req[j]) begin
          req[j] = ($urandom_range(0, 2) == 0);
          req_data[j*DW +: DW] = DW'($urandom);
        end else if ($urandom_range(0, 31) == 0) begin
          req[j] = 1'b0;
        end
      end
      rd = (int'($urandom_range(0, 3)) < rd_bias);
    end

    // Asynchronous reset with five entries stored
    tick();
    req = '0;
    rd  = 1'b1;
    repeat (12) tick();
    rd  = 1'b0;
    req = 4'b0001;
    repeat (5) tick();
    req = 4'b1111;
    check("lit_pre_rst_count", 32'(bus.o_count), 32'd5);
    #2;
    rst = 1'b1;
    #1;
    check("lit_async_count", 32'(bus.o_count), 32'd0);
    check("lit_async_empty", 32'(bus.o_empty), 32'd1);
    check("lit_async_grant", 32'(bus.o_grant), 32'd0);
    check("lit_async_wr_ptr", 32'(bus.o_b_wr_ptr), 32'd0);
    tick();
    rst = 1'b0;
    mid();
    check("lit_post_rst_grant", 32'(bus.o_grant), 32'd1);
    tick();
    req = '0;
    repeat (3) tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
